// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_arb_pkg                                                        |
// | Shared types and constants for the SDRAM port arbiter.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sdram_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} arb_state_e;
    typedef enum logic [1:0] {REQ_DN = 2'd0, REQ_CPU = 2'd1, REQ_SFX = 2'd2} req_id_e;
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;
endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_arb_if                                                         |
// | Requester and SDRAM-controller side signals of the port arbiter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sdram_arb_if #(
    parameter int ADDR_W = 25
);
    logic              dn_wr;
    logic [23:0]       dn_addr;
    logic [7:0]        dn_data;
    logic              dn_ack;
    logic              cpu_rd;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;
    logic              sfx_rd;
    logic [ADDR_W-1:0] sfx_addr;
    logic [7:0]        sfx_dout;
    logic              sfx_ack;
    logic [ADDR_W-1:0] sdram_addr;
    logic              sdram_rd;
    logic              sdram_wr;
    logic [7:0]        sdram_din;
    logic              sdram_ack;
    logic [7:0]        sdram_dout;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  dn_wr, dn_addr, dn_data, cpu_rd, cpu_addr, sfx_rd, sfx_addr,
        input  sdram_ack, sdram_dout,
        output dn_ack, cpu_dout, cpu_ack, sfx_dout, sfx_ack,
        output sdram_addr, sdram_rd, sdram_wr, sdram_din, busy, timeout_err
    );

    modport slave (
        output dn_wr, dn_addr, dn_data, cpu_rd, cpu_addr, sfx_rd, sfx_addr,
        output sdram_ack, sdram_dout,
        input  dn_ack, cpu_dout, cpu_ack, sfx_dout, sfx_ack,
        input  sdram_addr, sdram_rd, sdram_wr, sdram_din, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_arb_timer                                                      |
// | Clearable up-counter flagging expiry at LIMIT-1.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdram_arb_timer #(
    parameter int TO_W  = 8,
    parameter int LIMIT = 255
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  clr,
    input  wire  en,
    output logic expire
);
    localparam logic [TO_W-1:0] C_LAST = TO_W'(LIMIT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == C_LAST);
endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_port_arbiter                                                   |
// | Shares one SDRAM byte port: download first, CPU/sfx round-robin.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = 25,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  wire        clk_sys,
    input  wire        RESET_N,
    sdram_arb_if.master bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              prefer_sfx_q, prefer_sfx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [7:0]        din_q, din_d;
    logic              dn_ack_q, dn_ack_d, cpu_ack_q, cpu_ack_d, sfx_ack_q, sfx_ack_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d, sfx_dout_q, sfx_dout_d;
    logic              terr_q, terr_d;
    logic              tmr_clr, tmr_en, tmr_expire;
    logic [7:0]        rsp_data;

    sdram_arb_timer #(.TO_W(TO_W), .LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk   (clk_sys),
        .rst_n (RESET_N),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        prefer_sfx_d = prefer_sfx_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        din_d        = din_q;
        dn_ack_d     = 1'b0;
        cpu_ack_d    = 1'b0;
        sfx_ack_d    = 1'b0;
        cpu_dout_d   = cpu_dout_q;
        sfx_dout_d   = sfx_dout_q;
        terr_d       = terr_q;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        // A real ack beats a coincident expiry, so it also selects the data.
        rsp_data     = bus.sdram_ack ? bus.sdram_dout : TIMEOUT_FILL;
        case (state_q)
            S_IDLE: begin
                if (bus.dn_wr) begin
                    gnt_d   = REQ_DN;
                    addr_d  = ADDR_W'(bus.dn_addr);
                    din_d   = bus.dn_data;
                    wr_d    = 1'b1;
                    state_d = S_ISSUE;
                    tmr_clr = 1'b1;
                end else if (bus.cpu_rd && !(bus.sfx_rd && prefer_sfx_q)) begin
                    gnt_d        = REQ_CPU;
                    addr_d       = bus.cpu_addr;
                    rd_d         = 1'b1;
                    prefer_sfx_d = 1'b1;
                    state_d      = S_ISSUE;
                    tmr_clr      = 1'b1;
                end else if (bus.sfx_rd) begin
                    gnt_d        = REQ_SFX;
                    addr_d       = bus.sfx_addr;
                    rd_d         = 1'b1;
                    prefer_sfx_d = 1'b0;
                    state_d      = S_ISSUE;
                    tmr_clr      = 1'b1;
                end
            end
            S_ISSUE: begin
                tmr_en = 1'b1;
                if (bus.sdram_ack || tmr_expire) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                    if (!bus.sdram_ack) begin
                        terr_d = 1'b1;
                    end
                    case (gnt_q)
                        REQ_DN:  dn_ack_d = 1'b1;
                        REQ_CPU: begin
                            cpu_ack_d  = 1'b1;
                            cpu_dout_d = rsp_data;
                        end
                        default: begin
                            sfx_ack_d  = 1'b1;
                            sfx_dout_d = rsp_data;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            gnt_q        <= REQ_DN;
            prefer_sfx_q <= 1'b0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            din_q        <= '0;
            dn_ack_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            sfx_ack_q    <= 1'b0;
            cpu_dout_q   <= '0;
            sfx_dout_q   <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            prefer_sfx_q <= prefer_sfx_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            din_q        <= din_d;
            dn_ack_q     <= dn_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            sfx_ack_q    <= sfx_ack_d;
            cpu_dout_q   <= cpu_dout_d;
            sfx_dout_q   <= sfx_dout_d;
            terr_q       <= terr_d;
        end
    end

    assign bus.sdram_addr  = addr_q;
    assign bus.sdram_rd    = rd_q;
    assign bus.sdram_wr    = wr_q;
    assign bus.sdram_din   = din_q;
    assign bus.dn_ack      = dn_ack_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.sfx_ack     = sfx_ack_q;
    assign bus.cpu_dout    = cpu_dout_q;
    assign bus.sfx_dout    = sfx_dout_q;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdram_port_arbiter                                                |
// | Vector table plus corner-case sequences, acks checked via scoreboard.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int ADDR_W         = 25;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int TO_W           = 8;

    logic clk_sys = 1'b0;
    logic RESET_N = 1'b0;
    always #5 clk_sys = ~clk_sys;

    sdram_arb_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_port_arbiter #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) dut (
        .clk_sys(clk_sys),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } ack_t;

    typedef struct {
        logic              dn, cpu, sfx;
        logic [23:0]       dn_addr;
        logic [7:0]        dn_data;
        logic [ADDR_W-1:0] cpu_addr, sfx_addr;
        logic [1:0]        exp_id;
        logic [ADDR_W-1:0] exp_addr;
        logic [7:0]        rdata;
    } vec_t;

    ack_t exp_q[$];
    ack_t got, exp_e;
    int   n_pass  = 0;
    int   n_total = 0;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Every ack pulse must match the oldest expected completion.
    always @(negedge clk_sys) begin
        if (RESET_N && (bus.dn_ack || bus.cpu_ack || bus.sfx_ack)) begin
            check("ack_onehot", 32'($countones({bus.dn_ack, bus.cpu_ack, bus.sfx_ack})), 1);
            got.id   = bus.dn_ack ? REQ_DN : (bus.cpu_ack ? REQ_CPU : REQ_SFX);
            got.data = bus.cpu_ack ? bus.cpu_dout : (bus.sfx_ack ? bus.sfx_dout : 8'h00);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got id %0d data %0h, expected no ack", got.id, got.data);
            end else begin
                exp_e = exp_q.pop_front();
                check("ack_id", 32'(got.id), 32'(exp_e.id));
                if (exp_e.id != REQ_DN) check("ack_data", 32'(got.data), 32'(exp_e.data));
            end
        end
    end

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.sdram_rd || bus.sdram_wr) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("strobe_wait", 32'(bus.sdram_rd | bus.sdram_wr), 1);
    endtask

    task automatic serve(input string tag, input logic [1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] din, input logic [7:0] rdata, input int hold, input bit drop);
        bit ok;
        wait_strobe(ok);
        if (!ok) return;
        check({tag, "_rd"}, 32'(bus.sdram_rd), 32'(id != REQ_DN));
        check({tag, "_wr"}, 32'(bus.sdram_wr), 32'(id == REQ_DN));
        check({tag, "_addr"}, 32'(bus.sdram_addr), 32'(addr));
        if (id == REQ_DN) check({tag, "_din"}, 32'(bus.sdram_din), 32'(din));
        check({tag, "_busy"}, 32'(bus.busy), 1);
        tick(hold);
        check({tag, "_addr_hold"}, 32'(bus.sdram_addr), 32'(addr));
        check({tag, "_strobe_hold"}, 32'(bus.sdram_rd | bus.sdram_wr), 1);
        exp_q.push_back(ack_t'{id: id, data: rdata});
        bus.sdram_ack  = 1'b1;
        bus.sdram_dout = rdata;
        if (drop) begin
            bus.dn_wr  = 1'b0;
            bus.cpu_rd = 1'b0;
            bus.sfx_rd = 1'b0;
        end
        tick();
        bus.sdram_ack  = 1'b0;
        bus.sdram_dout = 8'h00;
        check({tag, "_strobe_clr"}, 32'({bus.sdram_rd, bus.sdram_wr}), 0);
        check({tag, "_busy_done"}, 32'(bus.busy), 1);
    endtask

    task automatic drive_reset();
        RESET_N    = 1'b0;
        bus.dn_wr  = 1'b0;
        bus.cpu_rd = 1'b0;
        bus.sfx_rd = 1'b0;
        bus.sdram_ack = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 24'h0, 8'h00, 25'h0000123, 25'h0, REQ_CPU, 25'h0000123, 8'h5A};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 24'h10, 8'hC3, 25'h0000200, 25'h300, REQ_DN, 25'h0000010, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 24'h0, 8'h00, 25'h0000200, 25'h300, REQ_SFX, 25'h0000300, 8'h11};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 24'h0, 8'h00, 25'h0000200, 25'h300, REQ_CPU, 25'h0000200, 8'h22};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 24'h0, 8'h00, 25'h0, 25'h1ABCDEF, REQ_SFX, 25'h1ABCDEF, 8'h33};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 24'h0, 8'h00, 25'h0FFFFFF, 25'h400, REQ_CPU, 25'h0FFFFFF, 8'h44};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 8'h3C, 25'h0, 25'h0, REQ_DN, 25'h0FFFFFF, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 24'hABCDEF, 8'h96, 25'h0, 25'h500, REQ_DN, 25'h0ABCDEF, 8'h00};

        bus.dn_wr = 1'b0; bus.dn_addr = '0; bus.dn_data = '0;
        bus.cpu_rd = 1'b0; bus.cpu_addr = '0;
        bus.sfx_rd = 1'b0; bus.sfx_addr = '0;
        bus.sdram_ack = 1'b0; bus.sdram_dout = '0;
        tick(2);
        check("rst_outputs", 32'({bus.sdram_rd, bus.sdram_wr, bus.busy, bus.timeout_err,
                                  bus.dn_ack, bus.cpu_ack, bus.sfx_ack}), 0);
        check("rst_addr", 32'(bus.sdram_addr), 0);
        check("rst_dout", 32'({bus.cpu_dout, bus.sfx_dout, bus.sdram_din}), 0);
        RESET_N = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            bus.dn_wr = tbl[i].dn; bus.dn_addr = tbl[i].dn_addr; bus.dn_data = tbl[i].dn_data;
            bus.cpu_rd = tbl[i].cpu; bus.cpu_addr = tbl[i].cpu_addr;
            bus.sfx_rd = tbl[i].sfx; bus.sfx_addr = tbl[i].sfx_addr;
            tick();
            check($sformatf("v%0d_latency", i), 32'(bus.sdram_rd | bus.sdram_wr), 1);
            serve($sformatf("v%0d", i), tbl[i].exp_id, tbl[i].exp_addr, tbl[i].dn_data,
                  tbl[i].rdata, 1 + (i % 3), 1'b1);
            tick();
            check($sformatf("v%0d_idle", i), 32'(bus.busy), 0);
        end
        check("cpu_dout_held", 32'(bus.cpu_dout), 32'h44);
        check("sfx_dout_held", 32'(bus.sfx_dout), 32'h33);

        bus.sdram_ack = 1'b1; bus.sdram_dout = 8'hEE;
        tick();
        bus.sdram_ack = 1'b0;
        check("idle_ack_ignored", 32'({bus.busy, bus.sdram_rd, bus.sdram_wr}), 0);
        tick();

        // Download priority, then CPU/sfx alternation with requests held.
        drive_reset();
        bus.dn_wr = 1'b1; bus.dn_addr = 24'h10; bus.dn_data = 8'hC3;
        bus.cpu_rd = 1'b1; bus.cpu_addr = 25'h0000A00;
        bus.sfx_rd = 1'b1; bus.sfx_addr = 25'h0000B00;
        tick();
        serve("prio_dn", REQ_DN, 25'h0000010, 8'hC3, 8'h00, 1, 1'b0);
        bus.dn_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) serve($sformatf("rr%0d_cpu", i), REQ_CPU, 25'h0000A00, 8'h00, 8'(8'h60 + i), 1, 1'b0);
            else            serve($sformatf("rr%0d_sfx", i), REQ_SFX, 25'h0000B00, 8'h00, 8'(8'h60 + i), 1, 1'b0);
        end
        bus.cpu_rd = 1'b0; bus.sfx_rd = 1'b0;
        tick(2);

        // Timeout: no sdram_ack ever arrives.
        drive_reset();
        bus.cpu_rd = 1'b1; bus.cpu_addr = 25'h0000055;
        tick();
        exp_q.push_back(ack_t'{id: REQ_CPU, data: TIMEOUT_FILL});
        bus.cpu_rd = 1'b0;
        begin
            int n;
            n = 0;
            while (bus.sdram_rd && n < 20) begin
                n++;
                tick();
            end
            check("timeout_len", 32'(n), TIMEOUT_CYCLES);
        end
        check("timeout_err_set", 32'(bus.timeout_err), 1);
        tick(2);
        check("timeout_idle", 32'(bus.busy), 0);
        bus.sfx_rd = 1'b1; bus.sfx_addr = 25'h0000777;
        tick();
        serve("after_to", REQ_SFX, 25'h0000777, 8'h00, 8'h33, 2, 1'b1);
        tick();
        check("timeout_err_sticky", 32'(bus.timeout_err), 1);
        RESET_N = 1'b0;
        #1;
        check("timeout_err_rst", 32'(bus.timeout_err), 0);
        tick();
        RESET_N = 1'b1;
        tick();

        // Ack lands on exactly the expiry cycle.
        bus.cpu_rd = 1'b1; bus.cpu_addr = 25'h0000066;
        tick();
        serve("coincide", REQ_CPU, 25'h0000066, 8'h00, 8'h77, TIMEOUT_CYCLES - 1, 1'b1);
        check("coincide_no_err", 32'(bus.timeout_err), 0);
        tick();
        check("coincide_dout", 32'(bus.cpu_dout), 32'h77);

        // Reset in the middle of a transaction.
        bus.cpu_rd = 1'b1; bus.cpu_addr = 25'h0000099;
        tick(3);
        RESET_N = 1'b0;
        #1;
        check("midrst_strobes", 32'({bus.sdram_rd, bus.sdram_wr, bus.busy}), 0);
        check("midrst_acks", 32'({bus.dn_ack, bus.cpu_ack, bus.sfx_ack}), 0);
        bus.cpu_rd = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        tick();
        bus.sfx_rd = 1'b1; bus.sfx_addr = 25'h0000ABC;
        tick();
        serve("post_rst", REQ_SFX, 25'h0000ABC, 8'h00, 8'h9C, 2, 1'b1);
        tick(3);
        check("sfx_dout_final", 32'(bus.sfx_dout), 32'h9C);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
